// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, legality check and pipeline latency.
package alu_pkg;

  localparam int unsigned OP_W        = 4;
  localparam int unsigned ALU_LATENCY = 2;

  localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b0011;
  localparam logic [OP_W-1:0] OP_SLTU = 4'b1011;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0100;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0101;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLL  = 4'b0111;
  localparam logic [OP_W-1:0] OP_SRL  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SRA  = 4'b1001;

  // NOP is not a legal issued operation; the ALU treats it as a bubble.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_AND,
      OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_arbiter_if.sv
// Requester, response and ALU-side bundle for the shared ALU issue arbiter.
interface alu_issue_arbiter_if
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
);
  logic              REQ0_VALID, REQ0_READY;
  logic [OP_W-1:0]   REQ0_OP;
  logic [XLEN-1:0]   REQ0_A, REQ0_B;
  logic [TAG_W-1:0]  REQ0_TAG;

  logic              REQ1_VALID, REQ1_READY;
  logic [OP_W-1:0]   REQ1_OP;
  logic [XLEN-1:0]   REQ1_A, REQ1_B;
  logic [TAG_W-1:0]  REQ1_TAG;

  logic              FLUSH;

  logic              ALU_EN;
  logic [OP_W-1:0]   ALU_OP_VAL;
  logic [XLEN-1:0]   ALU_A, ALU_B;
  logic [XLEN-1:0]   ALU_OUT;
  logic              ALU_ZERO, ALU_DONE;

  logic              RSP0_VALID, RSP0_ZERO, RSP0_ERR;
  logic [XLEN-1:0]   RSP0_DATA;
  logic [TAG_W-1:0]  RSP0_TAG;
  logic              RSP1_VALID, RSP1_ZERO, RSP1_ERR;
  logic [XLEN-1:0]   RSP1_DATA;
  logic [TAG_W-1:0]  RSP1_TAG;

  logic              BUSY;

  modport slave (
    input  REQ0_VALID, REQ0_OP, REQ0_A, REQ0_B, REQ0_TAG,
    input  REQ1_VALID, REQ1_OP, REQ1_A, REQ1_B, REQ1_TAG,
    input  FLUSH, ALU_OUT, ALU_ZERO, ALU_DONE,
    output REQ0_READY, REQ1_READY,
    output ALU_EN, ALU_OP_VAL, ALU_A, ALU_B,
    output RSP0_VALID, RSP0_DATA, RSP0_TAG, RSP0_ZERO, RSP0_ERR,
    output RSP1_VALID, RSP1_DATA, RSP1_TAG, RSP1_ZERO, RSP1_ERR,
    output BUSY
  );

  modport master (
    output REQ0_VALID, REQ0_OP, REQ0_A, REQ0_B, REQ0_TAG,
    output REQ1_VALID, REQ1_OP, REQ1_A, REQ1_B, REQ1_TAG,
    output FLUSH, ALU_OUT, ALU_ZERO, ALU_DONE,
    input  REQ0_READY, REQ1_READY,
    input  ALU_EN, ALU_OP_VAL, ALU_A, ALU_B,
    input  RSP0_VALID, RSP0_DATA, RSP0_TAG, RSP0_ZERO, RSP0_ERR,
    input  RSP1_VALID, RSP1_DATA, RSP1_TAG, RSP1_ZERO, RSP1_ERR,
    input  BUSY
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer remembers who won the last handshake.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_c_o
);

  logic last_q, last_d;

  // last_q = 1 means requester 1 won most recently, so requester 0 has priority.
  always_comb begin
    gnt_c_o = 2'b00;
    if (req_i[0] && (!req_i[1] || last_q)) begin
      gnt_c_o[0] = 1'b1;
    end else if (req_i[1]) begin
      gnt_c_o[1] = 1'b1;
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_c_o[1]) begin
      last_d = 1'b1;
    end else if (gnt_c_o[0]) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one 2-stage ALU between two requesters and routes results back by owner.
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
) (
  input logic               CK_REF,
  input logic               RST_N,
  alu_issue_arbiter_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic             owner;
    logic [TAG_W-1:0] tag;
    logic             err;
  } shadow_t;

  logic [1:0]       req, gnt;
  logic [OP_W-1:0]  sel_op;
  logic [TAG_W-1:0] sel_tag;
  shadow_t          s1_q, s1_d, s2_q, s2_d;

  assign req = {bus.REQ1_VALID, bus.REQ0_VALID};

  rr_arbiter2 u_arb (
    .clk_i   (CK_REF),
    .rst_ni  (RST_N),
    .req_i   (req),
    .gnt_c_o (gnt)
  );

  assign bus.REQ0_READY = gnt[0];
  assign bus.REQ1_READY = gnt[1];
  assign bus.ALU_EN     = 1'b1;

  // Operand mux; an idle cycle feeds the ALU an all-zero bubble.
  always_comb begin
    bus.ALU_OP_VAL = OP_NOP;
    bus.ALU_A      = XLEN'(0);
    bus.ALU_B      = XLEN'(0);
    sel_op         = OP_NOP;
    sel_tag        = TAG_W'(0);
    if (gnt[0]) begin
      bus.ALU_OP_VAL = bus.REQ0_OP;
      bus.ALU_A      = bus.REQ0_A;
      bus.ALU_B      = bus.REQ0_B;
      sel_op         = bus.REQ0_OP;
      sel_tag        = bus.REQ0_TAG;
    end else if (gnt[1]) begin
      bus.ALU_OP_VAL = bus.REQ1_OP;
      bus.ALU_A      = bus.REQ1_A;
      bus.ALU_B      = bus.REQ1_B;
      sel_op         = bus.REQ1_OP;
      sel_tag        = bus.REQ1_TAG;
    end
  end

  // Shadow pipe mirrors the ALU's input and output registers; FLUSH kills both stages.
  always_comb begin
    s1_d       = s1_q;
    s1_d.valid = (|gnt) && !bus.FLUSH;
    s1_d.owner = gnt[1];
    s1_d.tag   = sel_tag;
    s1_d.err   = !op_is_legal(sel_op);
    s2_d       = s1_q;
    s2_d.valid = s1_q.valid && !bus.FLUSH;
  end

  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // Response demux: only the owner sees a result; idle fields are held at zero.
  always_comb begin
    bus.RSP0_VALID = 1'b0;
    bus.RSP0_DATA  = XLEN'(0);
    bus.RSP0_TAG   = TAG_W'(0);
    bus.RSP0_ZERO  = 1'b0;
    bus.RSP0_ERR   = 1'b0;
    bus.RSP1_VALID = 1'b0;
    bus.RSP1_DATA  = XLEN'(0);
    bus.RSP1_TAG   = TAG_W'(0);
    bus.RSP1_ZERO  = 1'b0;
    bus.RSP1_ERR   = 1'b0;
    if (s2_q.valid && !s2_q.owner) begin
      bus.RSP0_VALID = 1'b1;
      bus.RSP0_DATA  = s2_q.err ? XLEN'(0) : bus.ALU_OUT;
      bus.RSP0_TAG   = s2_q.tag;
      bus.RSP0_ZERO  = bus.ALU_ZERO;
      bus.RSP0_ERR   = s2_q.err;
    end else if (s2_q.valid && s2_q.owner) begin
      bus.RSP1_VALID = 1'b1;
      bus.RSP1_DATA  = s2_q.err ? XLEN'(0) : bus.ALU_OUT;
      bus.RSP1_TAG   = s2_q.tag;
      bus.RSP1_ZERO  = bus.ALU_ZERO;
      bus.RSP1_ERR   = s2_q.err;
    end
  end

  assign bus.BUSY = s1_q.valid || s2_q.valid;

  a_alu_done: assert property (@(posedge CK_REF) disable iff (!RST_N)
    (s2_q.valid && !s2_q.err) |-> bus.ALU_DONE);

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a 2-stage ALU stand-in and a queue-based model.
module tb_alu_issue_arbiter;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  alu_issue_arbiter_if #(.XLEN(32), .TAG_W(4)) bus ();

  alu_issue_arbiter #(.XLEN(32), .TAG_W(4)) dut (
    .CK_REF (clk),
    .RST_N  (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: return {31'd0, a < b};
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return 32'($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  // Stand-in for the real ALU: input registers, then a registered result.
  logic [3:0]  alu_op_q;
  logic [31:0] alu_a_q, alu_b_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_q     <= 4'd0;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
      bus.ALU_OUT  <= 32'd0;
      bus.ALU_ZERO <= 1'b0;
      bus.ALU_DONE <= 1'b0;
    end else begin
      alu_op_q     <= bus.ALU_OP_VAL;
      alu_a_q      <= bus.ALU_A;
      alu_b_q      <= bus.ALU_B;
      bus.ALU_OUT  <= ref_alu(alu_op_q, alu_a_q, alu_b_q);
      bus.ALU_ZERO <= (ref_alu(alu_op_q, alu_a_q, alu_b_q) == 32'd0);
      bus.ALU_DONE <= op_is_legal(alu_op_q);
    end
  end

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk32(nm, 32'(act), 32'(exp));
  endtask

  // Model: expected responses in flight, keyed by the cycle they must appear.
  typedef struct {
    int          due;
    bit          owner;
    logic [3:0]  tag;
    bit          err;
    logic [31:0] data;
    bit          zero;
  } exp_t;

  exp_t q[$];
  int   last_win = 1;

  task automatic chk_rsp(input string nm, input bit ev, input exp_t e, input logic v,
                         input logic [31:0] d, input logic [3:0] t, input logic z,
                         input logic er);
    chk1({nm, "_valid"}, v, ev);
    chk32({nm, "_data"}, d, ev ? e.data : 32'd0);
    chk32({nm, "_tag"}, 32'(t), ev ? 32'(e.tag) : 32'd0);
    chk1({nm, "_zero"}, z, ev ? e.zero : 1'b0);
    chk1({nm, "_err"}, er, ev ? e.err : 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   found, er0, er1, eb;
    logic [3:0]  wop;
    logic [31:0] wa, wb;
    logic [3:0]  wtag;
    if (!rst_n) begin
      q.delete();
      last_win = 1;
    end
    er0 = bus.REQ0_VALID && (!bus.REQ1_VALID || last_win == 1);
    er1 = bus.REQ1_VALID && !er0;
    chk1("ready0", bus.REQ0_READY, er0);
    chk1("ready1", bus.REQ1_READY, er1);
    chk1("alu_en", bus.ALU_EN, 1'b1);
    wop  = er0 ? bus.REQ0_OP  : er1 ? bus.REQ1_OP  : OP_NOP;
    wa   = er0 ? bus.REQ0_A   : er1 ? bus.REQ1_A   : 32'd0;
    wb   = er0 ? bus.REQ0_B   : er1 ? bus.REQ1_B   : 32'd0;
    wtag = er0 ? bus.REQ0_TAG : bus.REQ1_TAG;
    chk32("alu_op", 32'(bus.ALU_OP_VAL), 32'(wop));
    chk32("alu_a", bus.ALU_A, wa);
    chk32("alu_b", bus.ALU_B, wb);

    found = 0;
    eb    = 0;
    e     = '{due: 0, owner: 0, tag: 4'd0, err: 0, data: 32'd0, zero: 0};
    foreach (q[i]) begin
      if (q[i].due == cyc) begin
        e     = q[i];
        found = 1;
      end
      if (q[i].due == cyc || q[i].due == cyc + 1) eb = 1;
    end
    chk_rsp("rsp0", found && !e.owner, e, bus.RSP0_VALID, bus.RSP0_DATA, bus.RSP0_TAG,
            bus.RSP0_ZERO, bus.RSP0_ERR);
    chk_rsp("rsp1", found && e.owner, e, bus.RSP1_VALID, bus.RSP1_DATA, bus.RSP1_TAG,
            bus.RSP1_ZERO, bus.RSP1_ERR);
    chk1("busy", bus.BUSY, eb);
    q = q.find(x) with (x.due > cyc);

    if (rst_n) begin
      if (bus.FLUSH) q.delete();
      if (er0 || er1) begin
        last_win = er1 ? 1 : 0;
        if (!bus.FLUSH) begin
          e.due   = cyc + int'(ALU_LATENCY);
          e.owner = er1;
          e.tag   = wtag;
          e.err   = !op_is_legal(wop);
          e.data  = e.err ? 32'd0 : ref_alu(wop, wa, wb);
          e.zero  = (e.data == 32'd0);
          q.push_back(e);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.REQ0_VALID = 1'b0;
    bus.REQ1_VALID = 1'b0;
    bus.FLUSH      = 1'b0;
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
    if (r == 0) begin
      bus.REQ0_VALID = 1'b1; bus.REQ0_OP = op; bus.REQ0_A = a; bus.REQ0_B = b;
      bus.REQ0_TAG = tag;
    end else begin
      bus.REQ1_VALID = 1'b1; bus.REQ1_OP = op; bus.REQ1_A = a; bus.REQ1_B = b;
      bus.REQ1_TAG = tag;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();
    set_req(0, OP_NOP, 32'd0, 32'd0, 4'd0);
    set_req(1, OP_NOP, 32'd0, 32'd0, 4'd0);
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("reset_busy", bus.BUSY, 1'b0);
    chk1("reset_rsp0_valid", bus.RSP0_VALID, 1'b0);
    chk1("reset_rsp1_valid", bus.RSP1_VALID, 1'b0);
    next_cycle();
    rst_n = 1'b1;

    // Single ADD on requester 0.
    set_req(0, OP_ADD, 32'd5, 32'd7, 4'd3);
    @(negedge clk);
    chk1("add_ready0", bus.REQ0_READY, 1'b1);
    chk1("add_ready1", bus.REQ1_READY, 1'b0);
    next_cycle(); idle();
    next_cycle();
    @(negedge clk);
    chk1("add_rsp0_valid", bus.RSP0_VALID, 1'b1);
    chk32("add_rsp0_data", bus.RSP0_DATA, 32'd12);
    chk32("add_rsp0_tag", 32'(bus.RSP0_TAG), 32'd3);
    chk1("add_rsp0_zero", bus.RSP0_ZERO, 1'b0);
    chk1("add_rsp1_valid", bus.RSP1_VALID, 1'b0);
    next_cycle();

    // Illegal opcode on requester 1.
    set_req(1, 4'hF, 32'h1234, 32'h5678, 4'hA);
    @(negedge clk);
    chk1("ill_ready1", bus.REQ1_READY, 1'b1);
    next_cycle(); idle();
    next_cycle();
    @(negedge clk);
    chk1("ill_rsp1_valid", bus.RSP1_VALID, 1'b1);
    chk1("ill_rsp1_err", bus.RSP1_ERR, 1'b1);
    chk32("ill_rsp1_data", bus.RSP1_DATA, 32'd0);
    chk32("ill_rsp1_tag", 32'(bus.RSP1_TAG), 32'hA);
    chk1("ill_rsp0_valid", bus.RSP0_VALID, 1'b0);
    next_cycle();

    // Contention: grants alternate 0,1,0,1 and responses follow in order.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        set_req(0, OP_SUB, 32'd9, 32'd9, 4'd1);
        set_req(1, OP_SLTU, 32'd1, 32'd2, 4'd2);
      end else begin
        idle();
      end
      @(negedge clk);
      if (i < 4) chk1("cont_ready0", bus.REQ0_READY, (i % 2) == 0);
      if (i >= 2) begin
        chk1("cont_rsp0_valid", bus.RSP0_VALID, (i % 2) == 0);
        chk1("cont_rsp1_valid", bus.RSP1_VALID, (i % 2) == 1);
        if ((i % 2) == 0) begin
          chk32("cont_rsp0_data", bus.RSP0_DATA, 32'd0);
          chk1("cont_rsp0_zero", bus.RSP0_ZERO, 1'b1);
        end else begin
          chk32("cont_rsp1_data", bus.RSP1_DATA, 32'd1);
        end
      end
      next_cycle();
    end

    // Arithmetic shift right of a negative value.
    set_req(0, OP_SRA, 32'h8000_0000, 32'd4, 4'd7);
    next_cycle(); idle();
    next_cycle();
    @(negedge clk);
    chk1("sra_rsp0_valid", bus.RSP0_VALID, 1'b1);
    chk32("sra_rsp0_data", bus.RSP0_DATA, 32'hF800_0000);
    chk32("sra_rsp0_tag", 32'(bus.RSP0_TAG), 32'd7);
    next_cycle();
    @(negedge clk);
    chk1("sra_rsp0_pulse", bus.RSP0_VALID, 1'b0);
    next_cycle();

    // Flush in the cycle after a grant, with a second grant in the flush cycle.
    set_req(0, OP_ADD, 32'd1, 32'd1, 4'd5);
    @(negedge clk);
    chk1("fl_ready0", bus.REQ0_READY, 1'b1);
    next_cycle();
    idle();
    set_req(1, OP_ADD, 32'd2, 32'd2, 4'd6);
    bus.FLUSH = 1'b1;
    @(negedge clk);
    chk1("fl_ready1", bus.REQ1_READY, 1'b1);
    chk1("fl_busy_before", bus.BUSY, 1'b1);
    next_cycle(); idle();
    @(negedge clk);
    chk1("fl_busy_after", bus.BUSY, 1'b0);
    chk1("fl_rsp0_killed", bus.RSP0_VALID, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("fl_rsp1_killed", bus.RSP1_VALID, 1'b0);
    chk1("fl_busy_idle", bus.BUSY, 1'b0);
    next_cycle();

    // Reset while an operation is in flight.
    set_req(0, OP_ADD, 32'd3, 32'd4, 4'd9);
    @(negedge clk);
    chk1("rst_ready0", bus.REQ0_READY, 1'b1);
    next_cycle(); idle();
    chk1("rst_busy_inflight", bus.BUSY, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rst_busy_async", bus.BUSY, 1'b0);
    chk1("rst_rsp0_async", bus.RSP0_VALID, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    set_req(0, OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 4'd1);
    set_req(1, OP_OR,  32'h0000_F0F0, 32'h0000_0FF0, 4'd2);
    @(negedge clk);
    chk1("post_rst_ready0", bus.REQ0_READY, 1'b1);
    chk1("post_rst_ready1", bus.REQ1_READY, 1'b0);
    chk1("post_rst_no_rsp", bus.RSP0_VALID, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("post_rst_ready1_next", bus.REQ1_READY, 1'b1);
    next_cycle(); idle();
    @(negedge clk);
    chk32("post_rst_and", bus.RSP0_DATA, 32'h0000_00F0);
    next_cycle();
    @(negedge clk);
    chk32("post_rst_or", bus.RSP1_DATA, 32'h0000_FFF0);
    repeat (3) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
